// File: rtl/packet_receiver.sv
// packet_receiver: GbE command-channel receive path.
// Strips preamble/SFD from byte-wide PHY data, runs the frame body through a
// 4-byte delay line so the trailing FCS can be compared against the running
// CRC-32. The receiver accepts a frame only if it is addressed to this station
// or to broadcast and carries the expected EtherType. It writes the body
// (destination MAC through the last payload byte) into an external buffer and
// hands accepted frames to the command logic with a ready/ack handshake.
//
// Ports:
//   clk, reset_n      rx clock, synchronous active-low reset
//   rx_data, rx_ctl   PHY byte and {dv^er, dv} control pair
//   mac_addr          station address, wire byte 0 = mac_addr[47:40]
//   rx_ack            one-cycle pulse releasing the held frame
//   buf_wen/waddr/wdata  command buffer write port
//   rx_ready, rx_length  held-frame flag and body length
//   good/bad/busy_count  wrapping 16-bit frame statistics
module packet_receiver #(
    parameter logic [15:0] ETHERTYPE = 16'h88b5,
    parameter int          MAX_BYTES = 64,
    parameter int          AW        = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    rx_data,
    input  logic [1:0]    rx_ctl,
    input  logic [47:0]   mac_addr,
    input  logic          rx_ack,
    output logic          buf_wen,
    output logic [AW-1:0] buf_waddr,
    output logic [7:0]    buf_wdata,
    output logic          rx_ready,
    output logic [AW:0]   rx_length,
    output logic [15:0]   good_count,
    output logic [15:0]   bad_count,
    output logic [15:0]   busy_count
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_e;

    localparam logic [AW:0] IDX_MAX      = (AW+1)'(MAX_BYTES);
    localparam logic [AW:0] IDX_DST_END  = (AW+1)'(6);
    localparam logic [AW:0] IDX_TYPE_HI  = (AW+1)'(12);
    localparam logic [AW:0] IDX_TYPE_LO  = (AW+1)'(13);
    localparam logic [AW:0] IDX_MIN_BODY = (AW+1)'(14);

    // Reflected IEEE 802.3 CRC-32 (poly 0x04C11DB7), one byte per call, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hedb88320;
            else                c = c >> 1;
        end
        return c;
    endfunction

    state_e        state_q;
    logic [31:0]   crc_q;
    logic [7:0]    dly_q [4];
    logic [2:0]    fill_q;
    logic [AW:0]   index_q;
    logic          dst_uni_q, dst_bc_q, type_ok_q;
    logic          buf_wen_q;
    logic [AW-1:0] buf_waddr_q;
    logic [7:0]    buf_wdata_q;
    logic          rx_ready_q;
    logic [AW:0]   rx_length_q;
    logic [15:0]   good_q, bad_q, busy_q;

    logic        dv, err;
    logic [7:0]  out_byte;
    logic [7:0]  mac_byte;
    logic [31:0] crc_d;
    logic [31:0] fcs_exp;
    logic        fcs_ok, runt;

    assign dv       = (rx_ctl == 2'b11);
    assign err      = (rx_ctl == 2'b01) || (rx_ctl == 2'b10);
    assign out_byte = dly_q[3];
    assign crc_d    = crc32_byte(crc_q, out_byte);

    // The FCS is the inverted CRC register sent low byte first; arrange it so
    // bits [31:24] are the first FCS byte on the wire.
    assign fcs_exp = {~crc_q[7:0], ~crc_q[15:8], ~crc_q[23:16], ~crc_q[31:24]};
    assign fcs_ok  = ({dly_q[3], dly_q[2], dly_q[1], dly_q[0]} == fcs_exp);

    // Fewer than 18 bytes after SFD: either the delay line never filled or
    // fewer than 14 body bytes made it out.
    assign runt = (fill_q != 3'd4) || (index_q < IDX_MIN_BODY);

    always_comb begin
        case (index_q[2:0])
            3'd0:    mac_byte = mac_addr[47:40];
            3'd1:    mac_byte = mac_addr[39:32];
            3'd2:    mac_byte = mac_addr[31:24];
            3'd3:    mac_byte = mac_addr[23:16];
            3'd4:    mac_byte = mac_addr[15:8];
            3'd5:    mac_byte = mac_addr[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    // NOTE: all state updates below use <= so every register sees the values
    // from before this edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            crc_q       <= '1;
            // NOTE: the delay line is only four flops, so it is cleared with
            // everything else; the external buffer RAM is never reset.
            for (int i = 0; i < 4; i++) dly_q[i] <= '0;
            fill_q      <= '0;
            index_q     <= '0;
            dst_uni_q   <= 1'b0;
            dst_bc_q    <= 1'b0;
            type_ok_q   <= 1'b0;
            buf_wen_q   <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= '0;
            rx_ready_q  <= 1'b0;
            rx_length_q <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            busy_q      <= '0;
        end else begin
            buf_wen_q <= 1'b0;
            if (rx_ack && rx_ready_q) rx_ready_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (dv) begin
                        if (rx_data == 8'h55) begin
                            state_q <= PREAMBLE;
                        end else begin
                            state_q <= DROP;
                            bad_q   <= bad_q + 16'd1;
                        end
                    end
                end

                PREAMBLE: begin
                    if (dv && rx_data == 8'h55) begin
                        state_q <= PREAMBLE;
                    end else if (dv && rx_data == 8'hd5) begin
                        state_q   <= DATA;
                        crc_q     <= '1;
                        fill_q    <= '0;
                        index_q   <= '0;
                        dst_uni_q <= 1'b1;
                        dst_bc_q  <= 1'b1;
                        type_ok_q <= 1'b1;
                    end else begin
                        state_q <= dv ? DROP : IDLE;
                        bad_q   <= bad_q + 16'd1;
                    end
                end

                DATA: begin
                    if (err) begin
                        state_q <= DROP;
                        bad_q   <= bad_q + 16'd1;
                    end else if (dv) begin
                        dly_q[0] <= rx_data;
                        for (int i = 1; i < 4; i++) dly_q[i] <= dly_q[i-1];
                        if (fill_q != 3'd4) begin
                            fill_q <= fill_q + 3'd1;
                        end else if (index_q == IDX_MAX) begin
                            // A body byte with nowhere to go: drop the frame now.
                            state_q <= DROP;
                            bad_q   <= bad_q + 16'd1;
                        end else begin
                            crc_q       <= crc_d;
                            buf_wen_q   <= !rx_ready_q;
                            buf_waddr_q <= index_q[AW-1:0];
                            buf_wdata_q <= out_byte;
                            index_q     <= index_q + (AW+1)'(1);
                            if (index_q < IDX_DST_END) begin
                                dst_uni_q <= dst_uni_q && (out_byte == mac_byte);
                                dst_bc_q  <= dst_bc_q && (out_byte == 8'hff);
                            end
                            if (index_q == IDX_TYPE_HI)
                                type_ok_q <= type_ok_q && (out_byte == ETHERTYPE[15:8]);
                            if (index_q == IDX_TYPE_LO)
                                type_ok_q <= type_ok_q && (out_byte == ETHERTYPE[7:0]);
                        end
                    end else begin
                        // End of frame: the delay line now holds the FCS.
                        state_q <= IDLE;
                        if (rx_ready_q) begin
                            busy_q <= busy_q + 16'd1;
                        end else if (runt || !fcs_ok) begin
                            bad_q <= bad_q + 16'd1;
                        end else if ((dst_uni_q || dst_bc_q) && type_ok_q) begin
                            rx_ready_q  <= 1'b1;
                            rx_length_q <= index_q;
                            good_q      <= good_q + 16'd1;
                        end
                    end
                end

                DROP: begin
                    if (!dv) state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign buf_wen    = buf_wen_q;
    assign buf_waddr  = buf_waddr_q;
    assign buf_wdata  = buf_wdata_q;
    assign rx_ready   = rx_ready_q;
    assign rx_length  = rx_length_q;
    assign good_count = good_q;
    assign bad_count  = bad_q;
    assign busy_count = busy_q;

endmodule
